// File: rtl/pe_group_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pe_group_ctrl_if
// Brief  : Control/handshake bundle between a PE-group sequencer and its group.
// Rev    : 1.0
// ============================================================================
interface pe_group_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 3
);
  logic               start;
  logic [3:0]         layer_in;
  logic               wb_en;
  logic               FinishWB;
  logic [2:0]         Process;
  logic               FinishFlag;
  logic [3:0]         layer;
  logic [ADDR_W-1:0]  ifmap_addr;
  logic [WADDR_W-1:0] weight_addr;
  logic               wb_commit;
  logic [ADDR_W-1:0]  wb_addr;
  logic               busy;
  logic               done;

  modport master (
    output start, layer_in, wb_en, FinishWB,
    input  Process, FinishFlag, layer, ifmap_addr, weight_addr,
           wb_commit, wb_addr, busy, done
  );

  modport slave (
    input  start, layer_in, wb_en, FinishWB,
    output Process, FinishFlag, layer, ifmap_addr, weight_addr,
           wb_commit, wb_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pe_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pe_group_ctrl
// Brief  : Walks every KxK window of an ifmap issuing one kernel row per cycle,
//          then drains the PE-group pipeline and numbers its write-backs.
// Rev    : 1.0
// ============================================================================
module pe_group_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 5,
  parameter int ADDR_W   = 10,
  parameter int WADDR_W  = 3,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  pe_group_ctrl_if.slave   bus
);

  localparam int C_OW    = IMG_W - K + 1;
  localparam int C_OH    = IMG_H - K + 1;
  localparam int C_N     = C_OW * C_OH * K;
  localparam int C_R_W   = (K > 1)        ? $clog2(K)          : 1;
  localparam int C_OX_W  = (C_OW > 1)     ? $clog2(C_OW)       : 1;
  localparam int C_OY_W  = (C_OH > 1)     ? $clog2(C_OH)       : 1;
  localparam int C_DR_W  = (PIPE_LAT > 0) ? $clog2(PIPE_LAT+1) : 1;
  localparam int C_CNT_W = $clog2(C_N + 1);

  localparam logic [2:0] C_P_IDLE  = 3'b000;
  localparam logic [2:0] C_P_START = 3'b001;
  localparam logic [2:0] C_P_DRAIN = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [C_R_W-1:0]    r_r;
  logic [C_OX_W-1:0]   r_ox;
  logic [C_OY_W-1:0]   r_oy;
  logic [C_DR_W-1:0]   r_drain;
  logic [C_CNT_W-1:0]  r_wb_cnt;
  logic [2:0]          r_process;
  logic                r_finish_flag;
  logic [3:0]          r_layer;
  logic [ADDR_W-1:0]   r_ifmap_addr;
  logic [WADDR_W-1:0]  r_weight_addr;
  logic                r_busy;
  logic                r_done;

  logic                w_r_last;
  logic                w_ox_last;
  logic                w_oy_last;
  logic                w_last_issue;
  logic [C_R_W-1:0]    w_r_nxt;
  logic [C_OX_W-1:0]   w_ox_nxt;
  logic [C_OY_W-1:0]   w_oy_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_accept;
  logic                w_commit;

  assign w_r_last     = (r_r  == C_R_W'(K - 1));
  assign w_ox_last    = (r_ox == C_OX_W'(C_OW - 1));
  assign w_oy_last    = (r_oy == C_OY_W'(C_OH - 1));
  assign w_last_issue = w_r_last && w_ox_last && w_oy_last;
  assign w_accept     = (r_state == S_IDLE) && bus.start;

  // Kernel row is innermost, then output column, then output row.
  always_comb begin
    w_r_nxt  = r_r + 1'b1;
    w_ox_nxt = r_ox;
    w_oy_nxt = r_oy;
    if (w_r_last) begin
      w_r_nxt = '0;
      if (w_ox_last) begin
        w_ox_nxt = '0;
        w_oy_nxt = r_oy + 1'b1;
      end else begin
        w_ox_nxt = r_ox + 1'b1;
      end
    end
  end

  assign w_addr_nxt = (ADDR_W'(w_oy_nxt) + ADDR_W'(w_r_nxt)) * ADDR_W'(IMG_W)
                      + ADDR_W'(w_ox_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_r           <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
      r_drain       <= '0;
      r_process     <= C_P_IDLE;
      r_finish_flag <= 1'b0;
      r_layer       <= '0;
      r_ifmap_addr  <= '0;
      r_weight_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state       <= S_RUN;
            r_layer       <= bus.layer_in;
            r_r           <= '0;
            r_ox          <= '0;
            r_oy          <= '0;
            r_process     <= C_P_START;
            r_busy        <= 1'b1;
            r_ifmap_addr  <= '0;
            r_weight_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_last_issue) begin
            r_state       <= S_DRAIN;
            r_process     <= C_P_DRAIN;
            r_finish_flag <= 1'b1;
            r_drain       <= '0;
          end else begin
            r_r           <= w_r_nxt;
            r_ox          <= w_ox_nxt;
            r_oy          <= w_oy_nxt;
            r_ifmap_addr  <= w_addr_nxt;
            r_weight_addr <= WADDR_W'(w_r_nxt);
          end
        end
        S_DRAIN: begin
          // Drain index 0..PIPE_LAT gives PIPE_LAT+1 drain cycles.
          if (r_drain == C_DR_W'(PIPE_LAT)) begin
            r_state       <= S_DONE;
            r_process     <= C_P_IDLE;
            r_finish_flag <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Results past the N-th are drain garbage and never commit.
  assign w_commit = r_busy && bus.wb_en && (r_wb_cnt < C_CNT_W'(C_N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_cnt <= '0;
    end else if (w_accept) begin
      r_wb_cnt <= '0;
    end else if (w_commit) begin
      r_wb_cnt <= r_wb_cnt + 1'b1;
    end
  end

  assign bus.Process     = r_process;
  assign bus.FinishFlag  = r_finish_flag;
  assign bus.layer       = r_layer;
  assign bus.ifmap_addr  = r_ifmap_addr;
  assign bus.weight_addr = r_weight_addr;
  assign bus.wb_commit   = w_commit;
  assign bus.wb_addr     = ADDR_W'(r_wb_cnt);
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

`ifndef SYNTHESIS
  a_finish_wb_by_done: assert property (
    @(posedge clk) disable iff (!rst) (r_state == S_DONE) |-> bus.FinishWB
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_group_ctrl
// Brief  : Scoreboard bench for pe_group_ctrl on an 8x8 ifmap with a 5x5 kernel.
// Rev    : 1.0
// ============================================================================
module tb_pe_group_ctrl;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 8;
  localparam int K        = 5;
  localparam int ADDR_W   = 10;
  localparam int WADDR_W  = 3;
  localparam int PIPE_LAT = 3;
  localparam int OW       = IMG_W - K + 1;
  localparam int OH       = IMG_H - K + 1;
  localparam int N        = OW * OH * K;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pe_group_ctrl_if #(.ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) bus ();

  pe_group_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W),
    .WADDR_W(WADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         done_seen = 0;
  int         q_addr[$];
  int         q_wt[$];
  int         q_wb[$];
  logic [3:0] exp_layer = 4'd0;
  bit   [2:0] hist      = 3'b000;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every window, every kernel row, in raster order.
  task automatic load_model();
    q_addr.delete();
    q_wt.delete();
    q_wb.delete();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int r = 0; r < K; r++) begin
          q_addr.push_back((oy + r) * IMG_W + ox);
          q_wt.push_back(r);
        end
    for (int i = 0; i < N; i++) q_wb.push_back(i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_Process"},     bus.Process,     0);
    check({tag, "_FinishFlag"},  bus.FinishFlag,  0);
    check({tag, "_layer"},       bus.layer,       0);
    check({tag, "_ifmap_addr"},  bus.ifmap_addr,  0);
    check({tag, "_weight_addr"}, bus.weight_addr, 0);
    check({tag, "_wb_commit"},   bus.wb_commit,   0);
    check({tag, "_wb_addr"},     bus.wb_addr,     0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_done"},        bus.done,        0);
  endtask

  task automatic issue_start(input logic [3:0] lay);
    load_model();
    exp_layer    = lay;
    bus.layer_in = lay;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", seen, 1);
  endtask

  task automatic check_idle(input string tag);
    repeat (3) tick();
    check({tag, "_idle_busy"},    bus.busy,    0);
    check({tag, "_idle_process"}, bus.Process, 0);
  endtask

  // PE-group stand-in: wb_en echoes (Start || FinishFlag) three cycles late.
  initial begin
    forever begin
      @(negedge clk);
      hist = {hist[1:0], (bus.Process == 3'b001) || bus.FinishFlag};
    end
  end

  initial begin
    bus.wb_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_en = hist[2];
    end
  end

  // Monitor / scoreboard.
  initial begin
    int cyc = 0, run_starts = 0, run_drain = 0, first_s = -1, first_c = -1, wb_seen = 0;
    int ea, ew;
    bus.FinishWB = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        run_starts = 0; run_drain = 0; first_s = -1; first_c = -1; wb_seen = 0;
        bus.FinishWB = 1'b0;
        continue;
      end
      if (bus.Process > 3'b010) check("process_code", bus.Process, 0);
      if (bus.Process == 3'b001) begin
        if (run_starts == 0) begin
          first_s = cyc;
          wb_seen = 0;
        end
        run_starts++;
        if (q_addr.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          ea = q_addr.pop_front();
          ew = q_wt.pop_front();
          check("ifmap_addr",  bus.ifmap_addr,  ea);
          check("weight_addr", bus.weight_addr, ew);
        end
      end
      if (bus.Process == 3'b010) begin
        if (run_drain == 0) check("drain_after_issues", run_starts, N);
        run_drain++;
        check("drain_finish_flag", bus.FinishFlag, 1);
      end else begin
        check("finish_flag_low", bus.FinishFlag, 0);
      end
      if (bus.wb_commit) begin
        if (first_c < 0) first_c = cyc;
        wb_seen++;
        if (q_wb.size() == 0) check("wb_unexpected", 1, 0);
        else                  check("wb_addr", bus.wb_addr, q_wb.pop_front());
      end
      bus.FinishWB = (wb_seen == N);
      if (bus.busy) check("layer_stable", bus.layer, exp_layer);
      if (bus.done) begin
        done_seen++;
        check("run_issue_count", run_starts, N);
        check("drain_cycles",    run_drain, PIPE_LAT + 1);
        check("wb_latency",      first_c - first_s, PIPE_LAT);
        check("issue_q_empty",   q_addr.size(), 0);
        check("wb_q_empty",      q_wb.size(), 0);
        run_starts = 0; run_drain = 0; first_s = -1; first_c = -1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] lay;
    bit         seen;
    bus.start    = 1'b0;
    bus.layer_in = 4'd0;
    rst          = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Plain layer.
    repeat ($urandom_range(0, 4)) tick();
    lay = 4'($urandom);
    issue_start(lay);
    wait_done();
    check_idle("run1");

    // Start pulses during RUN and coincident with done must be ignored.
    lay = 4'($urandom);
    issue_start(lay);
    repeat (9) tick();
    bus.start    = 1'b1;
    bus.layer_in = ~lay;
    tick();
    bus.start    = 1'b0;
    bus.layer_in = lay;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        bus.start    = 1'b1;
        bus.layer_in = ~lay;
        tick();
        bus.start    = 1'b0;
        break;
      end
    end
    check("done_timeout_spurious", seen, 1);
    check_idle("run2");

    // Asynchronous reset at RUN cycle 40, then a fresh layer.
    lay = 4'($urandom);
    issue_start(lay);
    repeat (39) tick();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    q_addr.delete();
    q_wt.delete();
    q_wb.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("post_reset_idle", bus.Process, 0);

    for (int run = 0; run < 3; run++) begin
      repeat ($urandom_range(0, 6)) tick();
      lay = 4'($urandom);
      issue_start(lay);
      wait_done();
      check_idle("run_rand");
    end

    check("done_pulse_total", done_seen, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
